// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and Funct3 decode for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Encodings 011/110/111 fall through to word; bit 2 never changes the size.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: return SZ_B;
      LSU_H, LSU_HU: return SZ_H;
      LSU_W:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == LSU_BU) || (f3 == LSU_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane placement for stores and extract/extend for loads
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = ld_word[{off, 3'b000} +: 8];
    lane_h  = ld_word[{off[1], 4'b0000} +: 16];
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = ld_word;
    case (size)
      SZ_B: begin
        be      = 4'b0001 << off;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sign_ext & lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be      = 4'b0011 << {off[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sign_ext & lane_h[15]}}, lane_h};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit bridging the datapath to a valid/ack bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  lsu_size_e   size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_store;
  lsu_size_e   cur_size;
  logic        misaligned;
  logic        stall_c, mis_c, buserr_c;
  logic [31:0] read_c;

  lsu_size_e   al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;

  // One aligner: fed live inputs while idle (store lanes), registered size/offset afterwards (load format).
  assign al_size = (state_q == IDLE) ? cur_size : size_q;
  assign al_off  = (state_q == IDLE) ? Mem_WrAddr[1:0] : off_q;

  lsu_align u_align (
    .size     (al_size),
    .off      (al_off),
    .sign_ext (sign_q),
    .st_data  (Mem_WrData),
    .ld_word  (rdata_q),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld)
  );

  always_comb begin
    is_store    = MemWrite;
    cur_size    = f3_size(Funct3);
    misaligned  = ((cur_size == SZ_H) && Mem_WrAddr[0]) ||
                  ((cur_size == SZ_W) && (Mem_WrAddr[1:0] != 2'b00));

    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    stall_c     = 1'b0;
    mis_c       = 1'b0;
    buserr_c    = 1'b0;
    read_c      = 32'h0;

    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (misaligned) begin
            mis_c = 1'b1;
          end else begin
            stall_c     = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {Mem_WrAddr[31:2], 2'b00};
            bus_wdata_d = is_store ? al_wdata : 32'h0;
            bus_be_d    = is_store ? al_be : 4'b1111;
            size_d      = cur_size;
            sign_d      = !is_store && !f3_unsigned(Funct3);
            off_d       = Mem_WrAddr[1:0];
            cnt_d       = 10'd0;
            rdata_d     = 32'h0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 10'd1;
        // Ack is checked first so an ack on the timeout cycle still completes.
        if (bus_ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_d == TMO) begin
          buserr_c  = 1'b1;
          rdata_d   = 32'h0;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        read_c  = bus_we_q ? 32'h0 : al_ld;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      size_q      <= SZ_W;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= 10'd0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  // The datapath must never see a stall or error pulse while reset is held.
  assign Stall       = stall_c & reset;
  assign MisalignErr = mis_c & reset;
  assign BusErr      = buserr_c & reset;
  assign ReadData    = read_c;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule
